// File: rtl/data_mem_wait.sv
// Word-addressed LSU data memory with byte-masked writes, programmable wait states and range errors.
// Optional misaligned-address rejection: define DATA_MEM_MISALIGN_CHECK_EN.
module data_mem_wait #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 4096,
  parameter int                    LATENCY     = 0,
  parameter logic [DATA_WIDTH-1:0] IDLE_DATA   = 32'hfa11_1eaf,
  parameter logic [DATA_WIDTH-1:0] OOR_DATA    = 32'hdead_beef
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    mem_req_i,
  input  logic                    write_enable_i,
  input  logic [DATA_WIDTH/8-1:0] byte_enable_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   write_data_i,
  output logic                    ready_o,
  output logic                    error_o,
  output logic [DATA_WIDTH-1:0]   read_data_o
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int OFF_BITS = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(BYTES - 1);
  localparam logic [3:0]            CNT_LOAD  = (LATENCY > 0) ? 4'(LATENCY - 1) : '0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic                  cap_we_q;
  logic [BYTES-1:0]      cap_be_q;
  logic [ADDR_WIDTH-1:0] cap_addr_q;
  logic [DATA_WIDTH-1:0] cap_wdata_q;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] ram [DEPTH_WORDS];

  logic                  accept;
  logic                  complete;
  logic                  op_we;
  logic [BYTES-1:0]      op_be;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic [DATA_WIDTH-1:0] op_wdata;
  logic [ADDR_WIDTH-1:0] op_idx;
  logic [IDX_W-1:0]      op_ram_idx;
  logic                  op_misalign;
  logic                  op_err;

  assign accept = mem_req_i && ((state_q == IDLE) || (state_q == RESP));

  // With zero latency the completion edge is the accept edge, so the live
  // request operands are used; otherwise the captured ones are.
  always_comb begin
    if (state_q == WAIT) begin
      op_we    = cap_we_q;
      op_be    = cap_be_q;
      op_addr  = cap_addr_q;
      op_wdata = cap_wdata_q;
    end else begin
      op_we    = write_enable_i;
      op_be    = byte_enable_i;
      op_addr  = addr_i;
      op_wdata = write_data_i;
    end
  end

  assign op_idx     = op_addr >> OFF_BITS;
  assign op_ram_idx = op_idx[IDX_W-1:0];

`ifdef DATA_MEM_MISALIGN_CHECK_EN
  assign op_misalign = |(op_addr & OFF_MASK);
`else
  assign op_misalign = 1'b0;
  logic unused_mask;
  assign unused_mask = |OFF_MASK;
`endif

  assign op_err = ({1'b0, op_idx} >= DEPTH_EXT) || op_misalign;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d  = RESP;
            complete = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d  = RESP;
          complete = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      read_data_o <= IDLE_DATA;
      cap_we_q    <= 1'b0;
      cap_be_q    <= '0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        cap_we_q    <= write_enable_i;
        cap_be_q    <= byte_enable_i;
        cap_addr_q  <= addr_i;
        cap_wdata_q <= write_data_i;
      end
      if (complete) begin
        err_q <= op_err;
        if (op_we)
          read_data_o <= IDLE_DATA;
        else if (op_err)
          read_data_o <= OOR_DATA;
        else
          read_data_o <= ram[op_ram_idx];
      end
    end
  end

  // Array is not reset; reset only suppresses a commit on its edge.
  always_ff @(posedge clk_i) begin
    if (!rst_i && complete && op_we && !op_err) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (op_be[b])
          ram[op_ram_idx][b*8 +: 8] <= op_wdata[b*8 +: 8];
      end
    end
  end

  assign ready_o = (state_q == RESP);
  assign error_o = ready_o && err_q;

endmodule

// File: tb/tb_data_mem_wait.sv
// Self-checking bench for data_mem_wait: three instances (latency 0, 2, 3) against a word-array model.
module tb_data_mem_wait;

  localparam logic [31:0] IDLE_D = 32'hfa11_1eaf;
  localparam logic [31:0] OOR_D  = 32'hdead_beef;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req [3];
  logic        we  = 1'b0;
  logic [3:0]  be  = '0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic        rdy [3];
  logic        err [3];
  logic [31:0] rd  [3];

  int lats [3] = '{0, 2, 3};
  int total = 0;
  int bad   = 0;

  logic [31:0] model [int];
  logic [31:0] exp_rd [3];

  always #5 clk = ~clk;

  data_mem_wait #(.LATENCY(0)) u_l0 (
    .clk_i(clk), .rst_i(rst), .mem_req_i(req[0]), .write_enable_i(we), .byte_enable_i(be),
    .addr_i(addr), .write_data_i(wdata), .ready_o(rdy[0]), .error_o(err[0]), .read_data_o(rd[0]));
  data_mem_wait #(.LATENCY(2)) u_l2 (
    .clk_i(clk), .rst_i(rst), .mem_req_i(req[1]), .write_enable_i(we), .byte_enable_i(be),
    .addr_i(addr), .write_data_i(wdata), .ready_o(rdy[1]), .error_o(err[1]), .read_data_o(rd[1]));
  data_mem_wait #(.LATENCY(3)) u_l3 (
    .clk_i(clk), .rst_i(rst), .mem_req_i(req[2]), .write_enable_i(we), .byte_enable_i(be),
    .addr_i(addr), .write_data_i(wdata), .ready_o(rdy[2]), .error_o(err[2]), .read_data_o(rd[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One transaction on instance k; ready must appear exactly lats[k] edges after accept.
  task automatic access(input int k, input bit w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] obs);
    logic [31:0] idx;
    logic [1:0]  low;
    bit          e;
    int          key;
    logic [31:0] word;
    idx = a >> 2;
    low = a[1:0];
    e   = (idx >= 32'd4096);
`ifdef DATA_MEM_MISALIGN_CHECK_EN
    if (low != 2'b00) e = 1'b1;
`else
    if (low != 2'b00) e = e;
`endif
    key = k * 4096 + int'(idx[11:0]);
    if (w) begin
      if (!e) begin
        word = model.exists(key) ? model[key] : 'x;
        for (int i = 0; i < 4; i++)
          if (b[i]) word[i*8 +: 8] = d[i*8 +: 8];
        model[key] = word;
      end
      exp_rd[k] = IDLE_D;
    end else begin
      exp_rd[k] = e ? OOR_D : (model.exists(key) ? model[key] : 'x);
    end

    @(negedge clk);
    we = w; be = b; addr = a; wdata = d; req[k] = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < lats[k]; i++) begin
      chk($sformatf("early_ready_l%0d", lats[k]), {31'd0, rdy[k]}, 32'd0);
      @(posedge clk); #1;
    end
    req[k] = 1'b0;
    obs = rd[k];
    chk($sformatf("ready_l%0d", lats[k]), {31'd0, rdy[k]}, 32'd1);
    chk($sformatf("error_l%0d", lats[k]), {31'd0, err[k]}, {31'd0, e});
    if (!(w && e)) chk($sformatf("rdata_l%0d", lats[k]), rd[k], exp_rd[k]);
    @(posedge clk); #1;
    chk($sformatf("strobe_end_l%0d", lats[k]), {31'd0, rdy[k]}, 32'd0);
    chk($sformatf("err_end_l%0d", lats[k]), {31'd0, err[k]}, 32'd0);
    if (!(w && e)) chk($sformatf("rdata_hold_l%0d", lats[k]), rd[k], exp_rd[k]);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    logic [31:0] pre;
    for (int k = 0; k < 3; k++) req[k] = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_ready", {31'd0, rdy[k]}, 32'd0);
      chk("reset_error", {31'd0, err[k]}, 32'd0);
      chk("reset_rdata", rd[k], IDLE_D);
      exp_rd[k] = IDLE_D;
    end

    // latency 0 write then read
    access(0, 1, 4'hF, 32'h10, 32'h1234_5678, r);
    access(0, 0, 4'h0, 32'h10, 32'h0, r);
    chk("l0_readback", r, 32'h1234_5678);

    // latency 3 partial write
    access(2, 1, 4'hF, 32'h40, 32'h1111_1111, r);
    access(2, 1, 4'b0101, 32'h40, 32'hAABB_CCDD, r);
    access(2, 0, 4'h0, 32'h40, 32'h0, r);
    chk("l3_partial", r, 32'h11BB_11DD);

    // out of range, including high address bits that would alias if truncated
    access(0, 1, 4'hF, 32'h0, 32'hCAFE_F00D, r);
    access(0, 0, 4'h0, 32'h4000, 32'h0, r);
    chk("oor_read", r, OOR_D);
    access(0, 1, 4'hF, 32'h4000, 32'h0BAD_0BAD, r);
    access(0, 1, 4'hF, 32'h8000_0000, 32'h0BAD_0BAD, r);
    access(0, 1, 4'hF, 32'h0001_0000, 32'h0BAD_0BAD, r);
    access(0, 0, 4'h0, 32'h0, 32'h0, r);
    chk("oor_word0_kept", r, 32'hCAFE_F00D);

    // zero-mask write on latency 2
    access(1, 1, 4'hF, 32'h30, 32'h7777_8888, r);
    access(1, 1, 4'h0, 32'h30, 32'h0000_0000, r);
    access(1, 0, 4'h0, 32'h30, 32'h0, r);
    chk("zero_mask", r, 32'h7777_8888);

    // reset one edge after accept on latency 2 drops the pending write
    access(1, 1, 4'hF, 32'h20, 32'h0BAD_F00D, r);
    @(negedge clk);
    we = 1'b1; be = 4'hF; addr = 32'h20; wdata = 32'h5555_AAAA; req[1] = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_wait", {31'd0, rdy[1]}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rst_mid_no_ready", {31'd0, rdy[1]}, 32'd0);
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) begin
      chk("rst_mid_rdata", rd[k], IDLE_D);
      exp_rd[k] = IDLE_D;
    end
    access(1, 0, 4'h0, 32'h20, 32'h0, r);
    chk("rst_mid_prewrite", r, 32'h0BAD_F00D);

    // misaligned read: word @0x10 unless the check is enabled
    access(0, 0, 4'h0, 32'h12, 32'h0, r);
`ifdef DATA_MEM_MISALIGN_CHECK_EN
    chk("misalign_read", r, OOR_D);
`else
    chk("misalign_read", r, 32'h1234_5678);
`endif

    // randomized traffic over a small initialised window per instance
    for (int k = 0; k < 3; k++) begin
      for (int wd = 0; wd < 16; wd++)
        access(k, 1, 4'hF, 32'(wd * 4), $urandom, r);
      for (int n = 0; n < 25; n++) begin
        a = 32'($urandom_range(0, 15) * 4);
        if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
        if ($urandom_range(0, 7) == 0) a = 32'h4000 + ($urandom & 32'h7FFF_FFFF);
        pre = $urandom;
        access(k, $urandom_range(0, 1) == 1, 4'($urandom), a, pre, r);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
